// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-RAM boot loader: FSM state
// encodings, word-packing constants and the word-count clamp helper.
package imem_boot_loader_pkg;

   // Loader FSM states, 2-bit encoding shared by every loader file.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_WRITE   = 2'd2,
      ST_DONE    = 2'd3
   } load_state_e;

   // Host bytes per instruction word and width of the byte index.
   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_IDX_W     = 2;

   // Clamp a requested word count to the RAM depth (unsigned compare).
   function automatic int unsigned clamp_count(input int unsigned req,
                                               input int unsigned depth);
      int unsigned res;
      if (req > depth) begin
         res = depth;
      end else begin
         res = req;
      end
      return res;
   endfunction

endpackage

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Assembles four host bytes into one 32-bit instruction word. The first
// byte of a word ends up in bits [31:24] (core's instruction byte order).
// The fourth byte is merged combinationally so the caller can register the
// complete word on the same edge that accepts that byte.
module imem_boot_loader_byte_word_packer
   import imem_boot_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_full
);

   logic [BYTE_IDX_W-1:0] idx_r;
   logic [23:0]           partial_r;
   logic [31:0]           word_s;
   logic                  full_s;

   localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);
   localparam logic [BYTE_IDX_W-1:0] IDX_ONE  = BYTE_IDX_W'(1);

   // Shift the incoming byte in below the bytes already collected.
   always_comb begin
      word_s = {partial_r, byte_data};
      full_s = byte_en & (idx_r == LAST_IDX);
   end

   // Byte index and partial-word register; clear discards a partial word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r     <= {BYTE_IDX_W{1'b0}};
         partial_r <= 24'h000000;
      end else if (clear) begin
         idx_r     <= {BYTE_IDX_W{1'b0}};
         partial_r <= 24'h000000;
      end else if (full_s) begin
         idx_r     <= {BYTE_IDX_W{1'b0}};
         partial_r <= 24'h000000;
      end else if (byte_en) begin
         idx_r     <= idx_r + IDX_ONE;
         partial_r <= word_s[23:0];
      end else begin
         idx_r     <= idx_r;
         partial_r <= partial_r;
      end
   end

   assign word      = word_s;
   assign word_full = full_s;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot-time sequencer for the instruction-RAM write port. Packs a host byte
// stream into 32-bit words, writes them to consecutive addresses from 0,
// then releases the core via core_run. Reload is possible from DONE
// without a chip reset. All outputs are registered.
module imem_boot_loader
   import imem_boot_loader_pkg::*;
#(
   parameter int ADDR_W = 7,
   parameter int DEPTH  = 128
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   num_words,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              iwen,
   output logic [ADDR_W-1:0] i_addr,
   output logic [31:0]       winst,
   output logic              core_run,
   output logic              busy,
   output logic              done,
   output logic              err_clamp
);

   localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   load_state_e       state_r;
   logic [ADDR_W:0]   count_r;
   logic [ADDR_W:0]   written_r;
   logic [ADDR_W-1:0] i_addr_r;
   logic [31:0]       winst_r;
   logic              iwen_r;
   logic              byte_ready_r;
   logic              core_run_r;
   logic              busy_r;
   logic              done_r;
   logic              err_clamp_r;

   logic              idle_like_s;
   logic              accept_s;
   logic              start_ok_s;
   logic              abort_ok_s;
   logic              clear_s;
   logic              clamp_hit_s;
   logic [ADDR_W:0]   count_next_s;
   logic [ADDR_W:0]   written_next_s;
   logic [31:0]       packed_s;
   logic              word_full_s;

   // Handshake, start/abort qualification and count clamping.
   always_comb begin
      idle_like_s    = (state_r == ST_IDLE) || (state_r == ST_DONE);
      accept_s       = byte_valid & byte_ready_r;
      // abort beats start; abort is only meaningful while loading
      start_ok_s     = start & ~abort & idle_like_s;
      abort_ok_s     = abort & ~idle_like_s;
      clear_s        = start_ok_s | abort_ok_s;
      clamp_hit_s    = (num_words > DEPTH_W);
      count_next_s   = (ADDR_W+1)'(clamp_count(32'(num_words), 32'(DEPTH)));
      written_next_s = written_r + CNT_ONE;
   end

   imem_boot_loader_byte_word_packer u_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear_s),
      .byte_en   (accept_s),
      .byte_data (byte_data),
      .word      (packed_s),
      .word_full (word_full_s)
   );

   // Loader FSM; every output is registered from the next-state decision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         count_r      <= CNT_ZERO;
         written_r    <= CNT_ZERO;
         i_addr_r     <= {ADDR_W{1'b0}};
         winst_r      <= 32'h00000000;
         iwen_r       <= 1'b0;
         byte_ready_r <= 1'b0;
         core_run_r   <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         err_clamp_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               iwen_r <= 1'b0;
               if (start_ok_s) begin
                  count_r     <= count_next_s;
                  written_r   <= CNT_ZERO;
                  i_addr_r    <= {ADDR_W{1'b0}};
                  err_clamp_r <= clamp_hit_s;
                  if (count_next_s == CNT_ZERO) begin
                     state_r      <= ST_DONE;
                     byte_ready_r <= 1'b0;
                     core_run_r   <= 1'b1;
                     busy_r       <= 1'b0;
                     done_r       <= 1'b1;
                  end else begin
                     state_r      <= ST_COLLECT;
                     byte_ready_r <= 1'b1;
                     core_run_r   <= 1'b0;
                     busy_r       <= 1'b1;
                     done_r       <= 1'b0;
                  end
               end else begin
                  state_r <= state_r;
               end
            end
            ST_COLLECT: begin
               iwen_r <= 1'b0;
               if (abort_ok_s) begin
                  state_r      <= ST_IDLE;
                  byte_ready_r <= 1'b0;
                  busy_r       <= 1'b0;
               end else if (word_full_s) begin
                  // fourth byte accepted: present the word for one cycle
                  state_r      <= ST_WRITE;
                  winst_r      <= packed_s;
                  iwen_r       <= 1'b1;
                  byte_ready_r <= 1'b0;
               end else begin
                  state_r <= ST_COLLECT;
               end
            end
            ST_WRITE: begin
               // the strobe in this cycle completes even if abort is high
               iwen_r    <= 1'b0;
               written_r <= written_next_s;
               if (abort_ok_s) begin
                  state_r      <= ST_IDLE;
                  byte_ready_r <= 1'b0;
                  busy_r       <= 1'b0;
               end else if (written_next_s == count_r) begin
                  // last word: address stays on it, so it never wraps to 0
                  state_r      <= ST_DONE;
                  byte_ready_r <= 1'b0;
                  busy_r       <= 1'b0;
                  core_run_r   <= 1'b1;
                  done_r       <= 1'b1;
               end else begin
                  state_r      <= ST_COLLECT;
                  byte_ready_r <= 1'b1;
                  i_addr_r     <= i_addr_r + ADDR_ONE;
               end
            end
            default: begin
               state_r      <= ST_IDLE;
               iwen_r       <= 1'b0;
               byte_ready_r <= 1'b0;
               core_run_r   <= 1'b0;
               busy_r       <= 1'b0;
               done_r       <= 1'b0;
            end
         endcase
      end
   end

   assign byte_ready = byte_ready_r;
   assign iwen       = iwen_r;
   assign i_addr     = i_addr_r;
   assign winst      = winst_r;
   assign core_run   = core_run_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign err_clamp  = err_clamp_r;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: expected RAM writes are queued when
// the bytes are driven and popped by a monitor when iwen pulses.
module tb_imem_boot_loader;

   localparam int ADDR_W = 7;
   localparam int DEPTH  = 128;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              abort;
   logic [ADDR_W:0]   num_words;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              iwen;
   logic [ADDR_W-1:0] i_addr;
   logic [31:0]       winst;
   logic              core_run;
   logic              busy;
   logic              done;
   logic              err_clamp;

   imem_boot_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .num_words  (num_words),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .iwen       (iwen),
      .i_addr     (i_addr),
      .winst      (winst),
      .core_run   (core_run),
      .busy       (busy),
      .done       (done),
      .err_clamp  (err_clamp)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   wr_t  exp_q[$];
   int   checks    = 0;
   int   errors    = 0;
   int   writes    = 0;
   int   acc_cnt   = 0;
   int   cyc       = 0;
   int   last4_cyc = -10;
   logic prev_iwen = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor: counts accepted bytes, checks each write against the scoreboard.
   always @(negedge clk) begin
      if (byte_valid && byte_ready) begin
         acc_cnt++;
         if (acc_cnt % 4 == 0) last4_cyc = cyc;
      end
      if (iwen) begin
         wr_t e;
         writes++;
         chk("iwen_single", prev_iwen, 0);
         chk("iwen_latency", cyc, last4_cyc + 1);
         chk("ready_in_write", byte_ready, 0);
         chk("sb_nonempty", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", i_addr, e.addr);
            chk("wr_data", winst, e.data);
         end
      end
      prev_iwen = iwen;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int n);
      start     = 1'b1;
      num_words = n[ADDR_W:0];
      tick();
      start     = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit got = 1'b0;
      byte_valid = 1'b1;
      byte_data  = b;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (byte_ready) got = 1'b1;
      end
      chk("byte_taken", got, 1);
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [ADDR_W-1:0] a, input logic [31:0] w);
      wr_t e;
      e.addr = a;
      e.data = w;
      exp_q.push_back(e);
      for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
   endtask

   task automatic wait_done(input string tag);
      bit got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (done) got = 1'b1;
      end
      chk(tag, got, 1);
   endtask

   task automatic run_basic(input string tag);
      writes  = 0;
      acc_cnt = 0;
      do_start(2);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_ready"}, byte_ready, 1);
      send_word(7'd0, 32'h13000000);
      send_word(7'd1, 32'h93001000);
      wait_done({tag, "_done"});
      chk({tag, "_core_run"}, core_run, 1);
      chk({tag, "_writes"}, writes, 2);
      chk({tag, "_sb_drain"}, exp_q.size(), 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_words = '0;
      byte_valid = 1'b0; byte_data = 8'h00;
      #12;
      chk("reset_outs", {byte_ready, iwen, i_addr, winst, core_run, busy, done, err_clamp}, 0);
      #5 rst_n = 1'b1;
      tick();
      chk("idle_outs", {byte_ready, iwen, core_run, busy, done}, 0);

      // 1: two words back-to-back
      run_basic("t1");

      // 2: byte_valid toggling, one word; start from DONE drops core_run
      writes  = 0;
      acc_cnt = 0;
      do_start(1);
      chk("t2_core_run_drop", core_run, 0);
      chk("t2_done_drop", done, 0);
      begin
         wr_t e;
         e.addr = 7'd0;
         e.data = 32'hA0A2A4A6;
         exp_q.push_back(e);
      end
      for (int i = 0; i < 14; i++) begin
         byte_valid = (i % 2 == 0);
         byte_data  = 8'hA0 + 8'(i);
         tick();
      end
      byte_valid = 1'b0;
      chk("t2_accepted", acc_cnt, 4);
      chk("t2_writes", writes, 1);
      chk("t2_done", done, 1);
      chk("t2_sb_drain", exp_q.size(), 0);

      // 3: oversized count clamps to DEPTH
      writes  = 0;
      acc_cnt = 0;
      do_start(200);
      chk("t3_err_clamp", err_clamp, 1);
      for (int a = 0; a < DEPTH; a++) begin
         logic [7:0] b;
         b = 8'(a);
         send_word(7'(a), {b, ~b, b ^ 8'h5A, 8'hC3});
      end
      wait_done("t3_done");
      chk("t3_writes", writes, DEPTH);
      chk("t3_sb_drain", exp_q.size(), 0);
      chk("t3_core_run", core_run, 1);

      // 4: zero-word load goes straight to DONE, clears err_clamp
      writes = 0;
      do_start(0);
      chk("t4_done", done, 1);
      chk("t4_core_run", core_run, 1);
      chk("t4_busy", busy, 0);
      chk("t4_err_clamp_clr", err_clamp, 0);
      tick(); tick(); tick();
      chk("t4_writes", writes, 0);

      // 5: abort mid-word discards it, then reload from address 0
      writes  = 0;
      acc_cnt = 0;
      do_start(5);
      send_word(7'd0, 32'h11223344);
      send_word(7'd1, 32'h55667788);
      send_word(7'd2, 32'h99AABBCC);
      send_byte(8'hEE);
      send_byte(8'hFF);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t5_abort_outs", {busy, core_run, done, byte_ready}, 0);
      for (int i = 0; i < 6; i++) tick();
      chk("t5_writes", writes, 3);
      chk("t5_sb_drain", exp_q.size(), 0);
      acc_cnt = 0;
      writes  = 0;
      do_start(1);
      chk("t5_reload_addr", i_addr, 0);
      send_word(7'd0, 32'hDEADBEEF);
      wait_done("t5_reload_done");
      chk("t5_reload_writes", writes, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t5_abort_in_done", {done, core_run}, 2'b11);

      // 6: asynchronous reset mid-COLLECT
      writes  = 0;
      acc_cnt = 0;
      do_start(2);
      send_byte(8'h11);
      send_byte(8'h22);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_reset_outs", {byte_ready, iwen, i_addr, winst, core_run, busy, done, err_clamp}, 0);
      #8 rst_n = 1'b1;
      tick();
      chk("t6_writes_none", writes, 0);
      run_basic("t6");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
